// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions for the inverse cipher: S-box tables, GF(2^8)
// helpers, round constants, key schedule steps and the controller state type.
package aes128_pkg;

   localparam int AES128_NR = 10;

   typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL} state_t;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Shift-and-add GF(2^8) multiply; with a constant b it folds to a few XORs.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Round constant lookup; indices outside 1..10 return zero.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 1; k <= 10; k++) begin
         if (idx == 4'(k)) r = RCON[k];
      end
      return r;
   endfunction

   // SubWord(RotWord(w)).
   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   // Forward schedule step rk_{i-1} -> rk_i.
   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = k;
      w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Backward schedule step rk_i -> rk_{i-1}; rc is rcon[i].
   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = k;
      w3 = w3 ^ w2;
      w2 = w2 ^ w1;
      w1 = w1 ^ w0;
      w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless last_round is set.
// Byte k of a 128-bit state sits at [127-8k -: 8], k = column*4 + row.
module aes_inv_round
   import aes128_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last_round,
   output logic [127:0] state_out
);

   logic [127:0] keyed;
   logic [127:0] mixed;

   // Row r is rotated right by r columns; the S-box and key XOR are fused per byte.
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
      assign keyed[127-8*gi -: 8] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*gi -: 8];
   end

   // InvMixColumns with the 0e/0b/0d/09 circulant matrix, one column per iteration.
   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = keyed[127-32*gi -: 8];
      assign a1 = keyed[119-32*gi -: 8];
      assign a2 = keyed[111-32*gi -: 8];
      assign a3 = keyed[103-32*gi -: 8];
      assign mixed[127-32*gi -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      assign mixed[119-32*gi -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      assign mixed[111-32*gi -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      assign mixed[103-32*gi -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
   end

   assign state_out = last_round ? keyed : mixed;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher. Expands the cipher key forward to rk10,
// then runs one inverse round per cycle while stepping the key backwards.
// Optional feature: define AES_DEC_KEY_CACHE_EN to keep the last key and its
// rk10 so a repeated key skips the forward expansion.
module aes128_decrypt_iter
   import aes128_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         valid_in,
   input  logic [127:0] data_in,
   input  logic [127:0] key_in,
   output logic [127:0] data_out,
   output logic         valid_out,
   output logic         done,
   output logic         busy
);

   if (NR != AES128_NR) begin : g_nr_unsupported
      $error("aes128_decrypt_iter supports only NR = 10");
   end

   state_t        fsm_reg;
   logic [3:0]    round_cnt_reg;
   logic [127:0]  state_reg;
   logic [127:0]  key_reg;
   logic [127:0]  data_out_reg;
   logic          done_reg;
   logic          busy_reg;

   logic [127:0]  round_out;
   logic [127:0]  key_fwd_val;
   logic [127:0]  key_inv_val;
   logic [7:0]    rcon_val;

`ifdef AES_DEC_KEY_CACHE_EN
   logic          cache_valid_reg;
   logic [127:0]  cache_key_reg;
   logic [127:0]  cache_rk10_reg;
   logic [127:0]  key_in_reg;
   logic          cache_hit;

   assign cache_hit = cache_valid_reg && (key_in == cache_key_reg);
`endif

   // The round counter doubles as the rcon index in both schedule directions.
   assign rcon_val    = rcon(round_cnt_reg);
   assign key_fwd_val = key_fwd(key_reg, rcon_val);
   assign key_inv_val = key_inv(key_reg, rcon_val);

   aes_inv_round u_inv_round (
      .state_in   (state_reg),
      .round_key  (key_reg),
      .last_round (fsm_reg == FINAL),
      .state_out  (round_out)
   );

   // Controller, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_reg       <= IDLE;
         round_cnt_reg <= 4'd0;
         state_reg     <= '0;
         key_reg       <= '0;
         data_out_reg  <= '0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
         cache_valid_reg <= 1'b0;
         cache_key_reg   <= '0;
         cache_rk10_reg  <= '0;
         key_in_reg      <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (fsm_reg)
            IDLE: begin
               if (start && valid_in) begin
                  state_reg <= data_in;
                  busy_reg  <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
                  key_in_reg <= key_in;
                  if (cache_hit) begin
                     key_reg       <= cache_rk10_reg;
                     round_cnt_reg <= 4'(NR);
                     fsm_reg       <= ADDKEY;
                  end else begin
                     key_reg       <= key_in;
                     round_cnt_reg <= 4'd1;
                     fsm_reg       <= KEYEXP;
                  end
`else
                  key_reg       <= key_in;
                  round_cnt_reg <= 4'd1;
                  fsm_reg       <= KEYEXP;
`endif
               end
            end
            KEYEXP: begin
               key_reg <= key_fwd_val;
               if (round_cnt_reg == 4'(NR)) begin
                  fsm_reg <= ADDKEY;
`ifdef AES_DEC_KEY_CACHE_EN
                  cache_valid_reg <= 1'b1;
                  cache_key_reg   <= key_in_reg;
                  cache_rk10_reg  <= key_fwd_val;
`endif
               end else begin
                  round_cnt_reg <= round_cnt_reg + 4'd1;
               end
            end
            ADDKEY: begin
               state_reg     <= state_reg ^ key_reg;
               key_reg       <= key_inv_val;
               round_cnt_reg <= 4'(NR - 1);
               fsm_reg       <= ROUND;
            end
            ROUND: begin
               state_reg <= round_out;
               key_reg   <= key_inv_val;
               if (round_cnt_reg == 4'd1) begin
                  round_cnt_reg <= 4'd0;
                  fsm_reg       <= FINAL;
               end else begin
                  round_cnt_reg <= round_cnt_reg - 4'd1;
               end
            end
            FINAL: begin
               data_out_reg <= round_out;
               done_reg     <= 1'b1;
               busy_reg     <= 1'b0;
               fsm_reg      <= IDLE;
            end
            default: begin
               fsm_reg <= IDLE;
            end
         endcase
      end
   end

   assign data_out  = data_out_reg;
   assign valid_out = done_reg;
   assign done      = done_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench for aes128_decrypt_iter: known FIPS-197 vectors, an
// ignored mid-block start, reset abort, loopback against a forward-cipher
// model, and back-to-back latency (cache-aware when AES_DEC_KEY_CACHE_EN is set).
module tb_aes128_decrypt_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         valid_in;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic [127:0] data_out;
   logic         valid_out;
   logic         done;
   logic         busy;

   aes128_decrypt_iter dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .key_in    (key_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   typedef struct {
      logic [127:0] pt;
      int           t0;
      int           lat;
   } exp_t;

   exp_t         sb_q[$];
   int           checks_cnt = 0;
   int           errors_cnt = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   int           exp_done_cnt = 0;
   logic [7:0]   m_sb [256];
   bit           m_cache_valid = 1'b0;
   logic [127:0] m_cache_key = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---- independent forward-cipher model ----
   function automatic logic [7:0] m_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = m_xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] m_sbox_calc(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] p = x;
      logic [7:0] e = 8'd254;
      logic [7:0] s;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = m_mul(r, p);
         p = m_mul(p, p);
      end
      s = r ^ ((r << 1) | (r >> 7)) ^ ((r << 2) | (r >> 6)) ^ ((r << 3) | (r >> 5)) ^ ((r << 4) | (r >> 4)) ^ 8'h63;
      return s;
   endfunction

   function automatic logic [127:0] m_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] st, rk;
      logic [31:0]  w [4];
      logic [7:0]   b [16];
      logic [7:0]   s [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      rk = key;
      st = pt ^ key;
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 4; i++) w[i] = rk[127-32*i -: 32];
         w[0] = w[0] ^ {m_sb[w[3][23:16]], m_sb[w[3][15:8]], m_sb[w[3][7:0]], m_sb[w[3][31:24]]} ^ {rc, 24'h0};
         w[1] = w[1] ^ w[0];
         w[2] = w[2] ^ w[1];
         w[3] = w[3] ^ w[2];
         rk = {w[0], w[1], w[2], w[3]};
         rc = m_xt(rc);
         for (int k = 0; k < 16; k++) b[k] = st[127-8*k -: 8];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[c*4+r] = m_sb[b[((c + r) % 4)*4 + r]];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
               s[c*4]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
               s[c*4+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
               s[c*4+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
               s[c*4+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
            end
         end
         for (int k = 0; k < 16; k++) st[127-8*k -: 8] = s[k];
         st = st ^ rk;
      end
      return st;
   endfunction

   // ---- monitor: pop and compare on every done ----
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_out !== done) check("valid_out_vs_done", {127'd0, valid_out}, {127'd0, done});
         if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
               check("spurious_done", 128'd1, 128'd0);
            end else begin
               e = sb_q.pop_front();
               check("data_out", data_out, e.pt);
               check("latency", 128'(cyc - e.t0), 128'(e.lat));
               check("busy_at_done", {127'd0, busy}, 128'd0);
            end
         end
      end
   end

   // ---- driver ----
   task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
      exp_t e;
      int   n = 0;
      bit   hit;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("accept_timeout", {127'd0, busy}, 128'd0);
      hit = CACHE_EN && m_cache_valid && (key == m_cache_key);
      if (CACHE_EN && !hit) begin
         m_cache_valid = 1'b1;
         m_cache_key   = key;
      end
      start    = 1'b1;
      valid_in = 1'b1;
      data_in  = ct;
      key_in   = key;
      e.pt  = pt;
      e.t0  = cyc;
      e.lat = hit ? 12 : 22;
      sb_q.push_back(e);
      exp_done_cnt++;
      $display("send key=%h ct=%h exp_pt=%h exp_lat=%0d", key, ct, pt, e.lat);
      @(negedge clk);
      start    = 1'b0;
      valid_in = 1'b0;
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      check("busy_after_accept", {127'd0, busy}, 128'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", 128'(sb_q.size()), 128'd0);
         exp_done_cnt -= sb_q.size();
         sb_q.delete();
      end
   endtask

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      logic [127:0] rk, rp;
      for (int i = 0; i < 256; i++) m_sb[i] = m_sbox_calc(8'(i));

      rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = '0; key_in = '0;
      repeat (3) @(negedge clk);
      check("reset_data_out", data_out, 128'd0);
      check("reset_valid_out", {127'd0, valid_out}, 128'd0);
      check("reset_done", {127'd0, done}, 128'd0);
      check("reset_busy", {127'd0, busy}, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 C.1 and App. B
      send(K1, C1, P1);
      drain();
      send(K2, C2, P2);
      drain();

      // Zero key, with a start pulse that must be ignored while busy
      send(128'd0, C3, 128'd0);
      repeat (4) @(negedge clk);
      start = 1'b1; valid_in = 1'b1;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      key_in  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      start = 1'b0; valid_in = 1'b0;
      drain();
      repeat (30) @(negedge clk);

      // Reset part-way through vector 1: no done, outputs cleared
      send(K1, C1, P1);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      exp_done_cnt -= sb_q.size();
      sb_q.delete();
      m_cache_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("abort_data_out", data_out, 128'd0);
      check("abort_valid_out", {127'd0, valid_out}, 128'd0);
      check("abort_done", {127'd0, done}, 128'd0);
      check("abort_busy", {127'd0, busy}, 128'd0);
      repeat (30) @(negedge clk);
      send(K1, C1, P1);
      drain();

      // Loopback through the forward model
      for (int i = 0; i < 8; i++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         send(rk, m_enc(rp, rk), rp);
         drain();
      end

      // Back-to-back, same key: second accept lands in the done cycle
      send(K1, C1, P1);
      send(K1, C1, P1);
      drain();
      repeat (5) @(negedge clk);

      check("done_count", 128'(done_cnt), 128'(exp_done_cnt));
      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
